mmio_initiator: RTL and testbench
=================================

# mmio_initiator

Host-side MMIO request generator for CCI-P: accepts read/write commands on a valid/ready port and drives the MMIO request fields a CCI-P AFU sees on its receive channel (c0 mmioRdValid/mmioWrValid, address, TID, data). It collects the AFU's read responses from the c2 transmit channel, matches them by TID and enforces a response timeout. It is used to exercise AFU register maps such as the 4-bit adder AFU, both in simulation harnesses and in on-chip loopback tests.

## Interface
Parameters:
- TIMEOUT_CYCLES, 512: maximum cycles from read issue to response before timeout.
- TID_W, 9: width of the MMIO transaction ID (CCI-P tid).

Ports:
- clock  in  1  CCI-P clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_size  in  1  0 = 32-bit (4 B), 1 = 64-bit (8 B).
- cmd_addr  in  16  DW (32-bit) address, as in the CCI-P MMIO header.
- cmd_wdata  in  64  write data; only [31:0] is meaningful for 32-bit.
- mmio_wr_valid  out  1  one-cycle write request strobe.
- mmio_rd_valid  out  1  one-cycle read request strobe.
- mmio_addr  out  16  request DW address.
- mmio_length  out  2  00 = 4 B, 01 = 8 B.
- mmio_tid  out  TID_W  request TID.
- mmio_wdata  out  64  request write data.
- rsp_valid  in  1  AFU read response valid (c2 mmioRdValid).
- rsp_tid  in  TID_W  response TID.
- rsp_data  in  64  response data.
- rd_done  out  1  one-cycle pulse: read completed.
- rd_data  out  64  read result, held until the next rd_done/rd_timeout.
- rd_timeout  out  1  one-cycle pulse: read timed out.
- cmd_error  out  1  one-cycle pulse: command rejected (misaligned).
- busy  out  1  state != IDLE.

## Operation
- Reset values: cmd_ready 0 while reset asserted, 1 on the first cycle after release; all other outputs 0; TID counter 0; state IDLE.
- States: IDLE, ISSUE, WAIT_RSP.
- IDLE: cmd_ready = 1. On accept: a 64-bit command with cmd_addr[0] = 1 is misaligned -> cmd_error pulse next cycle, no bus activity, stay IDLE. Otherwise latch addr/size/data and go to ISSUE.
- ISSUE (one cycle): drive exactly one of mmio_wr_valid/mmio_rd_valid for one cycle with latched fields; mmio_tid = TID counter. Write -> IDLE. Read -> WAIT_RSP, clear timeout counter.
- TID counter increments by 1 after every issued read, wrapping 2^TID_W-1 -> 0; writes do not consume TIDs.
- WAIT_RSP: response with rsp_tid == issued TID -> rd_data = rsp_data (upper 32 bits zeroed for 32-bit reads), rd_done pulse, -> IDLE. rsp_valid with non-matching TID is ignored. No match within TIMEOUT_CYCLES -> rd_data = all ones, rd_timeout pulse, -> IDLE.
- rsp_valid in IDLE/ISSUE (late or stray response) is ignored; it never produces rd_done.
- Only one read outstanding; writes are posted (no response).
- mmio_addr/length/tid/wdata are don't-care when both strobes are low but hold their last values.

## Timing
- Command accepted at cycle T -> strobe high at T+1 exactly one cycle; cmd_ready low from T+1.
- Write: cmd_ready high again at T+2 (one write per 2 cycles max).
- Read issued at I = T+1: response accepted on any cycle I+1 .. I+TIMEOUT_CYCLES. Matching response at cycle R -> rd_done and new rd_data at R+1, cmd_ready high at R+1.
- No match by I+TIMEOUT_CYCLES -> rd_timeout at I+TIMEOUT_CYCLES+1. Matching response on cycle I+TIMEOUT_CYCLES wins over timeout.
- Response on the same cycle as the strobe (I) is not accepted.
- Misaligned command at T -> cmd_error at T+1, cmd_ready stays high.
- reset asserted mid-transaction: immediate return to reset values, outstanding read abandoned (no rd_done/rd_timeout), TID counter back to 0.

## Structure
- Package mmio_initiator_pkg: state enum, MMIO length constants (LEN_4B = 2'b00, LEN_8B = 2'b01), default TID width.
- Single module; the timeout counter and TID counter are local, with no sub-module warranted.

## Test plan
- Write 64-bit, addr 0x0010, data 0x5 -> mmio_wr_valid one cycle at T+1, mmio_length 01, mmio_tid unchanged, cmd_ready high at T+2.
- Read addr 0x0014, model responds tid 0 data 0x9 after 3 cycles -> rd_done once, rd_data 0x9, next read carries tid 1.
- Read with model response tid 5 (wrong) then tid 0 -> first ignored, rd_done on the second.
- Read with no response, TIMEOUT_CYCLES = 16 -> rd_timeout exactly 17 cycles after strobe, rd_data 0xFFFF_FFFF_FFFF_FFFF; a response arriving later produces nothing.
- 64-bit read at addr 0x0003 -> cmd_error pulse, no strobe; 513 consecutive reads -> TID wraps 511 -> 0.
- Reset asserted while in WAIT_RSP -> all outputs 0 asynchronously, no completion pulse, first read after release uses tid 0.

Source files
------------

// File: rtl/mmio_initiator_pkg.sv
// Shared types and constants for the CCI-P MMIO request generator.
package mmio_initiator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2
    } state_t;

    localparam logic [1:0] LEN_4B = 2'b00;
    localparam logic [1:0] LEN_8B = 2'b01;

    localparam int DEFAULT_TID_W          = 9;
    localparam int DEFAULT_TIMEOUT_CYCLES = 512;

    // A 64-bit access must start on an even DW address.
    function automatic logic is_misaligned(input logic size_64, input logic addr_lsb);
        return size_64 & addr_lsb;
    endfunction

endpackage

// File: rtl/mmio_initiator.sv
// Host-side CCI-P MMIO initiator: issues one read or posted write per command,
// matches read responses by TID and bounds the wait with a timeout.
module mmio_initiator
    import mmio_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int TID_W          = DEFAULT_TID_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic             cmd_size,
    input  logic [15:0]      cmd_addr,
    input  logic [63:0]      cmd_wdata,
    output logic             mmio_wr_valid,
    output logic             mmio_rd_valid,
    output logic [15:0]      mmio_addr,
    output logic [1:0]       mmio_length,
    output logic [TID_W-1:0] mmio_tid,
    output logic [63:0]      mmio_wdata,
    input  logic             rsp_valid,
    input  logic [TID_W-1:0] rsp_tid,
    input  logic [63:0]      rsp_data,
    output logic             rd_done,
    output logic [63:0]      rd_data,
    output logic             rd_timeout,
    output logic             cmd_error,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q;
    state_t           state_d;
    logic             out_of_reset_q;
    logic             wr_q;
    logic             size_q;
    logic [TID_W-1:0] tid_cnt_q;
    logic [TO_W-1:0]  to_cnt_q;

    logic cmd_fire;
    logic cmd_bad;
    logic cmd_go;
    logic rsp_match;
    logic timed_out;

    // Command handshake: a command transfers on a rising edge where
    // cmd_valid && cmd_ready; cmd_ready does not depend on cmd_valid.
    assign cmd_fire  = cmd_valid & cmd_ready;
    assign cmd_bad   = is_misaligned(cmd_size, cmd_addr[0]);
    assign cmd_go    = cmd_fire & ~cmd_bad;
    assign rsp_match = (state_q == ST_WAIT_RSP) && rsp_valid && (rsp_tid == mmio_tid);
    assign timed_out = (state_q == ST_WAIT_RSP) && (to_cnt_q == TO_LAST) && !rsp_match;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (cmd_go) state_d = ST_ISSUE;
            ST_ISSUE:    state_d = wr_q ? ST_IDLE : ST_WAIT_RSP;
            ST_WAIT_RSP: if (rsp_match || timed_out) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready     = out_of_reset_q && (state_q == ST_IDLE);
        mmio_wr_valid = (state_q == ST_ISSUE) && wr_q;
        mmio_rd_valid = (state_q == ST_ISSUE) && !wr_q;
        busy          = (state_q != ST_IDLE);
        dbg_state     = state_q;
    end

    // Request fields are captured at accept and held until the next command,
    // so mmio_tid keeps the issued TID while the counter moves on.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_of_reset_q <= 1'b0;
            wr_q           <= 1'b0;
            size_q         <= 1'b0;
            mmio_addr      <= '0;
            mmio_length    <= LEN_4B;
            mmio_tid       <= '0;
            mmio_wdata     <= '0;
        end else begin
            out_of_reset_q <= 1'b1;
            if (cmd_go) begin
                wr_q        <= cmd_write;
                size_q      <= cmd_size;
                mmio_addr   <= cmd_addr;
                mmio_length <= cmd_size ? LEN_8B : LEN_4B;
                mmio_tid    <= tid_cnt_q;
                mmio_wdata  <= cmd_wdata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tid_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            if (mmio_rd_valid) begin
                tid_cnt_q <= tid_cnt_q + TID_W'(1);
                to_cnt_q  <= '0;
            end else if (state_q == ST_WAIT_RSP) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_done    <= 1'b0;
            rd_timeout <= 1'b0;
            cmd_error  <= 1'b0;
            rd_data    <= '0;
        end else begin
            rd_done    <= rsp_match;
            rd_timeout <= timed_out;
            cmd_error  <= cmd_fire & cmd_bad;
            if (rsp_match) begin
                rd_data <= size_q ? rsp_data : {32'h0, rsp_data[31:0]};
            end else if (timed_out) begin
                rd_data <= '1;
            end
        end
    end

endmodule

// File: tb/tb_mmio_initiator.sv
// Bench for mmio_initiator: directed vector table, hand-written corner
// sequences and randomized traffic against a transaction-level model.
module tb_mmio_initiator;

    localparam int TO = 16;
    localparam int TW = 9;

    logic          clock;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic          cmd_size;
    logic [15:0]   cmd_addr;
    logic [63:0]   cmd_wdata;
    logic          mmio_wr_valid;
    logic          mmio_rd_valid;
    logic [15:0]   mmio_addr;
    logic [1:0]    mmio_length;
    logic [TW-1:0] mmio_tid;
    logic [63:0]   mmio_wdata;
    logic          rsp_valid;
    logic [TW-1:0] rsp_tid;
    logic [63:0]   rsp_data;
    logic          rd_done;
    logic [63:0]   rd_data;
    logic          rd_timeout;
    logic          cmd_error;
    logic          busy;
    logic [1:0]    dbg_state;

    mmio_initiator #(.TIMEOUT_CYCLES(TO), .TID_W(TW)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
        .mmio_addr(mmio_addr), .mmio_length(mmio_length), .mmio_tid(mmio_tid),
        .mmio_wdata(mmio_wdata), .rsp_valid(rsp_valid), .rsp_tid(rsp_tid),
        .rsp_data(rsp_data), .rd_done(rd_done), .rd_data(rd_data),
        .rd_timeout(rd_timeout), .cmd_error(cmd_error), .busy(busy),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks   = 0;
    int failures = 0;

    logic [64:0]   exp_q[$];
    logic [64:0]   sb_e;
    logic [TW-1:0] model_tid;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference read outcome: {timed_out, rd_data} from response delay and size.
    function automatic logic [64:0] ref_read(input int delay, input bit size, input logic [63:0] data);
        if (delay > TO) return {1'b1, {64{1'b1}}};
        return {1'b0, size ? data : {32'h0, data[31:0]}};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        if (reset === 1'b1 && (rd_done === 1'b1 || rd_timeout === 1'b1)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL stray_completion actual=done%0b_to%0b required=none at %0t",
                         rd_done, rd_timeout, $time);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_kind", {63'h0, rd_timeout}, {63'h0, sb_e[64]});
                chk("sb_data", rd_data, sb_e[63:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue_cmd(input bit wr, input bit size, input logic [15:0] addr,
                             input logic [63:0] data);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("cmd_ready_wait", {63'h0, cmd_ready}, 64'h1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_size  = size;
        cmd_addr  = addr;
        cmd_wdata = data;
        step();
        cmd_valid = 1'b0;
        cmd_wdata = {$urandom, $urandom};
    endtask

    task automatic do_write(input bit size, input logic [15:0] addr, input logic [63:0] data);
        issue_cmd(1'b1, size, addr, data);
        chk("wr_strobe", {63'h0, mmio_wr_valid}, 64'h1);
        chk("wr_no_rd", {63'h0, mmio_rd_valid}, 64'h0);
        chk("wr_addr", {48'h0, mmio_addr}, {48'h0, addr});
        chk("wr_len", {62'h0, mmio_length}, size ? 64'h1 : 64'h0);
        chk("wr_data", mmio_wdata, data);
        chk("wr_tid", {55'h0, mmio_tid}, {55'h0, model_tid});
        chk("wr_ready_low", {63'h0, cmd_ready}, 64'h0);
        step();
        chk("wr_strobe_end", {63'h0, mmio_wr_valid}, 64'h0);
        chk("wr_ready_back", {63'h0, cmd_ready}, 64'h1);
    endtask

    task automatic do_bad(input bit wr, input logic [15:0] addr);
        issue_cmd(wr, 1'b1, addr, 64'h0);
        chk("err_pulse", {63'h0, cmd_error}, 64'h1);
        chk("err_no_strobe", {62'h0, mmio_wr_valid, mmio_rd_valid}, 64'h0);
        chk("err_ready", {63'h0, cmd_ready}, 64'h1);
        step();
        chk("err_pulse_end", {63'h0, cmd_error}, 64'h0);
        chk("err_no_strobe2", {62'h0, mmio_wr_valid, mmio_rd_valid}, 64'h0);
    endtask

    task automatic do_read(input bit size, input logic [15:0] addr, input int delay,
                           input logic [63:0] data, input bit noise, input bit early,
                           input logic [64:0] expect_res);
        logic [TW-1:0] t;
        logic [TW-1:0] bad;
        t   = model_tid;
        bad = t + TW'(5);
        issue_cmd(1'b0, size, addr, 64'h0);
        chk("rd_strobe", {63'h0, mmio_rd_valid}, 64'h1);
        chk("rd_no_wr", {63'h0, mmio_wr_valid}, 64'h0);
        chk("rd_tid", {55'h0, mmio_tid}, {55'h0, t});
        chk("rd_addr", {48'h0, mmio_addr}, {48'h0, addr});
        chk("rd_len", {62'h0, mmio_length}, size ? 64'h1 : 64'h0);
        model_tid = t + TW'(1);
        exp_q.push_back(expect_res);
        if (early) begin
            rsp_valid = 1'b1;
            rsp_tid   = t;
            rsp_data  = ~data;
        end
        if (!expect_res[64]) begin
            for (int c = 1; c <= delay; c++) begin
                step();
                if (c == 1) chk("rd_strobe_end", {63'h0, mmio_rd_valid}, 64'h0);
                rsp_valid = (c == delay) || noise;
                rsp_tid   = (c == delay) ? t : bad;
                rsp_data  = (c == delay) ? data : ~data;
            end
            step();
            rsp_valid = 1'b0;
            chk("rd_done", {63'h0, rd_done}, 64'h1);
            chk("rd_data", rd_data, expect_res[63:0]);
            chk("rd_ready_back", {63'h0, cmd_ready}, 64'h1);
            step();
            chk("rd_done_end", {63'h0, rd_done}, 64'h0);
        end else begin
            for (int c = 1; c <= TO; c++) begin
                step();
                rsp_valid = noise;
                rsp_tid   = bad;
                rsp_data  = ~data;
                if (c == TO) chk("to_not_early", {63'h0, rd_timeout}, 64'h0);
            end
            step();
            rsp_valid = 1'b0;
            chk("to_pulse", {63'h0, rd_timeout}, 64'h1);
            chk("to_data", rd_data, {64{1'b1}});
            chk("to_ready_back", {63'h0, cmd_ready}, 64'h1);
            rsp_valid = 1'b1;
            rsp_tid   = t;
            rsp_data  = data;
            step();
            rsp_valid = 1'b0;
            chk("late_rsp_ignored", {62'h0, rd_done, rd_timeout}, 64'h0);
            step();
            chk("late_rsp_ignored2", {63'h0, rd_done}, 64'h0);
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          write;
        bit          size;
        logic [15:0] addr;
        logic [63:0] data;
        int          delay;
        bit          noise;
        bit          early;
        bit          exp_err;
        logic [64:0] exp_res;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [63:0] d;
        logic [15:0] a;
        bit          sz;
        bit          nz;
        bit          er;
        int          dl;
        int          kind;

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_size  = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_valid = 1'b0;
        rsp_tid   = '0;
        rsp_data  = '0;
        model_tid = '0;

        vecs[0] = '{1'b1, 1'b1, 16'h0010, 64'h5,                   0,  1'b0, 1'b0, 1'b0, 65'h0};
        vecs[1] = '{1'b0, 1'b1, 16'h0014, 64'h9,                   3,  1'b0, 1'b0, 1'b0, {1'b0, 64'h9}};
        vecs[2] = '{1'b0, 1'b1, 16'h0018, 64'h77,                  2,  1'b1, 1'b0, 1'b0, {1'b0, 64'h77}};
        vecs[3] = '{1'b0, 1'b0, 16'h0020, 64'hDEADBEEF_12345678,   1,  1'b0, 1'b0, 1'b0, {1'b0, 64'h12345678}};
        vecs[4] = '{1'b0, 1'b1, 16'h0022, 64'hCAFEF00D_0BADBEEF,   TO, 1'b1, 1'b1, 1'b0, {1'b0, 64'hCAFEF00D_0BADBEEF}};
        vecs[5] = '{1'b0, 1'b0, 16'h0005, 64'h1234,                TO + 1, 1'b0, 1'b0, 1'b0, {1'b1, {64{1'b1}}}};
        vecs[6] = '{1'b0, 1'b1, 16'h0003, 64'h0,                   0,  1'b0, 1'b0, 1'b1, 65'h0};
        vecs[7] = '{1'b1, 1'b1, 16'h0003, 64'h0,                   0,  1'b0, 1'b0, 1'b1, 65'h0};
        vecs[8] = '{1'b1, 1'b0, 16'h0007, 64'h11112222_33334444,   0,  1'b0, 1'b0, 1'b0, 65'h0};

        // reset state
        step();
        step();
        chk("rst_ready", {63'h0, cmd_ready}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_strobes", {62'h0, mmio_wr_valid, mmio_rd_valid}, 64'h0);
        chk("rst_pulses", {61'h0, rd_done, rd_timeout, cmd_error}, 64'h0);
        chk("rst_rd_data", rd_data, 64'h0);
        chk("rst_fields", {mmio_addr, mmio_tid, mmio_length}, 64'h0);
        reset = 1'b1;
        step();
        chk("ready_after_release", {63'h0, cmd_ready}, 64'h1);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].exp_err) do_bad(vecs[i].write, vecs[i].addr);
            else if (vecs[i].write) do_write(vecs[i].size, vecs[i].addr, vecs[i].data);
            else do_read(vecs[i].size, vecs[i].addr, vecs[i].delay, vecs[i].data,
                         vecs[i].noise, vecs[i].early, vecs[i].exp_res);
        end

        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 9);
            a    = 16'($urandom);
            d    = {$urandom, $urandom};
            sz   = 1'($urandom);
            if (kind == 9) begin
                do_bad(1'($urandom), a | 16'h1);
            end else begin
                if (sz) a[0] = 1'b0;
                if (kind < 4) begin
                    do_write(sz, a, d);
                end else begin
                    dl = $urandom_range(1, TO + 3);
                    nz = 1'($urandom);
                    er = 1'($urandom);
                    do_read(sz, a, dl, d, nz, er, ref_read(dl, sz, d));
                end
            end
        end

        // TID wrap across 2^TW-1 -> 0
        for (int i = 0; i < 513; i++) begin
            d = {$urandom, $urandom};
            do_read(1'b1, 16'h0100, 1, d, 1'b0, 1'b0, ref_read(1, 1'b1, d));
        end

        // reset while a read is outstanding
        issue_cmd(1'b0, 1'b1, 16'h0040, 64'h0);
        step();
        step();
        chk("pre_reset_busy", {63'h0, busy}, 64'h1);
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", {63'h0, cmd_ready}, 64'h0);
        chk("mid_rst_busy", {63'h0, busy}, 64'h0);
        chk("mid_rst_strobes", {62'h0, mmio_wr_valid, mmio_rd_valid}, 64'h0);
        chk("mid_rst_pulses", {61'h0, rd_done, rd_timeout, cmd_error}, 64'h0);
        chk("mid_rst_rd_data", rd_data, 64'h0);
        chk("mid_rst_tid", {55'h0, mmio_tid}, 64'h0);
        model_tid = '0;
        step();
        step();
        chk("in_rst_no_pulse", {62'h0, rd_done, rd_timeout}, 64'h0);
        reset = 1'b1;
        step();
        chk("post_rst_ready", {63'h0, cmd_ready}, 64'h1);
        for (int c = 0; c < TO + 3; c++) begin
            step();
            chk("abandoned_silent", {62'h0, rd_done, rd_timeout}, 64'h0);
        end
        d = 64'hA5A5_5A5A_0F0F_F0F0;
        do_read(1'b0, 16'h0044, 2, d, 1'b0, 1'b0, ref_read(2, 1'b0, d));

        step();
        chk("sb_drained", 64'(exp_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
